// File: rtl/sequenciador_linha_param_pkg.sv
// ============================================================================
// Module : sequenciador_pkg
// Brief  : State encodings and default sizing for the bottling line sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package sequenciador_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE       = 3'd0;
  localparam logic [STATE_W-1:0] ST_MOVE       = 3'd1;
  localparam logic [STATE_W-1:0] ST_RUN        = 3'd2;
  localparam logic [STATE_W-1:0] ST_MOVE_FINAL = 3'd3;
  localparam logic [STATE_W-1:0] ST_COUNT      = 3'd4;
  localparam logic [STATE_W-1:0] ST_PAUSED     = 3'd5;
  localparam logic [STATE_W-1:0] ST_FAULT      = 3'd6;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE       = ST_IDLE,
    S_MOVE       = ST_MOVE,
    S_RUN        = ST_RUN,
    S_MOVE_FINAL = ST_MOVE_FINAL,
    S_COUNT      = ST_COUNT,
    S_PAUSED     = ST_PAUSED,
    S_FAULT      = ST_FAULT
  } state_t;

  localparam int DEF_BATCH_SIZE  = 12;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_TIMEOUT_CYC = 50_000_000;

endpackage

`default_nettype wire

// File: rtl/sequenciador_linha_param_if.sv
// ============================================================================
// Module : sequenciador_linha_param_if
// Brief  : Station/conveyor handshake bundle between sequencer and the line.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface sequenciador_linha_param_if
  import sequenciador_pkg::*;
#(
  parameter int N_STAGES   = 3,
  parameter int BATCH_SIZE = DEF_BATCH_SIZE,
  parameter int CNT_W      = DEF_CNT_W
);

  logic                          start;
  logic                          alarme_rolha;
  logic                          sensor_final;
  logic                          esteira_concluida;
  logic [N_STAGES-1:0]           stage_done;
  logic                          garrafa_aprovada;

  logic                          cmd_mover_esteira;
  logic [N_STAGES-1:0]           cmd_stage;
  logic                          batch_complete;
  logic [$clog2(BATCH_SIZE)-1:0] item_count;
  logic [CNT_W-1:0]              batch_count;
  logic [CNT_W-1:0]              reject_count;
  logic                          paused;
  logic                          fault;
  logic [$clog2(N_STAGES)-1:0]   stage_idx;

  modport master (
    input  start, alarme_rolha, sensor_final, esteira_concluida, stage_done, garrafa_aprovada,
    output cmd_mover_esteira, cmd_stage, batch_complete, item_count, batch_count,
           reject_count, paused, fault, stage_idx
  );

  modport slave (
    output start, alarme_rolha, sensor_final, esteira_concluida, stage_done, garrafa_aprovada,
    input  cmd_mover_esteira, cmd_stage, batch_complete, item_count, batch_count,
           reject_count, paused, fault, stage_idx
  );

endinterface

`default_nettype wire

// File: rtl/sequenciador_linha_param_watchdog.sv
// ============================================================================
// Module : temporizador_watchdog
// Brief  : Wait-state timeout counter; expired stays high until cleared.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module temporizador_watchdog
  import sequenciador_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int TO_W        = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && !expired) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expired = (r_count == LIMIT);

endmodule

`default_nettype wire

// File: rtl/sequenciador_linha_param.sv
// ============================================================================
// Module : sequenciador_linha_param
// Brief  : Bottling line master: per-station sequencing, pause/resume, batches.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sequenciador_linha_param
  import sequenciador_pkg::*;
#(
  parameter int                  N_STAGES    = 3,
  parameter logic [N_STAGES-1:0] MOVE_MASK   = N_STAGES'(3'b101),
  parameter int                  BATCH_SIZE  = DEF_BATCH_SIZE,
  parameter int                  CNT_W       = DEF_CNT_W,
  parameter int                  TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int                  TO_W        = 26
) (
  input  logic                       clk,
  input  logic                       reset,
  sequenciador_linha_param_if.master bus
);

  localparam int                 SIDX_W   = $clog2(N_STAGES);
  localparam int                 IC_W     = $clog2(BATCH_SIZE);
  localparam logic [SIDX_W-1:0]  LAST_IDX = SIDX_W'(N_STAGES - 1);
  localparam logic [IC_W-1:0]    ITEM_MAX = IC_W'(BATCH_SIZE - 1);

  state_t              r_state, r_saved;
  logic [SIDX_W-1:0]   r_idx;
  logic [IC_W-1:0]     r_item;
  logic [CNT_W-1:0]    r_batch, r_reject;
  logic                r_batch_complete, r_sensor_prev;

  state_t              w_next, w_next_saved, w_base;
  logic [SIDX_W-1:0]   w_next_idx, w_base_idx, w_inc_idx;
  logic                w_base_reject, w_reject_inc, w_count_inc;
  logic                w_expired, w_sensor_rise, w_active;
  logic [N_STAGES-1:0] w_cmd_stage;

  assign w_inc_idx     = r_idx + 1'b1;
  assign w_sensor_rise = bus.sensor_final && !r_sensor_prev;
  assign w_active      = (r_state == S_MOVE) || (r_state == S_RUN) || (r_state == S_MOVE_FINAL);

  always_comb begin
    w_next        = r_state;
    w_next_saved  = r_saved;
    w_next_idx    = r_idx;
    w_base        = r_state;
    w_base_idx    = r_idx;
    w_base_reject = 1'b0;
    w_reject_inc  = 1'b0;
    w_count_inc   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.alarme_rolha) begin
            w_next       = S_PAUSED;
            w_next_saved = S_IDLE;
          end else begin
            w_next_idx = '0;
            w_next     = MOVE_MASK[0] ? S_MOVE : S_RUN;
          end
        end
      end
      S_MOVE: begin
        if (bus.esteira_concluida) w_base = S_RUN;
        else if (w_expired)        w_base = S_FAULT;
      end
      S_RUN: begin
        if (bus.stage_done[r_idx]) begin
          if (r_idx == LAST_IDX) begin
            if (bus.garrafa_aprovada) begin
              w_base = S_MOVE_FINAL;
            end else begin
              w_base        = S_IDLE;
              w_base_reject = 1'b1;
            end
          end else begin
            w_base_idx = w_inc_idx;
            w_base     = MOVE_MASK[w_inc_idx] ? S_MOVE : S_RUN;
          end
        end else if (w_expired) begin
          w_base = S_FAULT;
        end
      end
      S_MOVE_FINAL: begin
        if (bus.esteira_concluida) w_base = S_COUNT;
        else if (w_expired)        w_base = S_FAULT;
      end
      S_COUNT: begin
        if (w_sensor_rise) begin
          w_next      = S_IDLE;
          w_count_inc = 1'b1;
        end else if (w_expired) begin
          w_next = S_FAULT;
        end
      end
      S_PAUSED: begin
        if (!bus.alarme_rolha && bus.start) w_next = r_saved;
      end
      S_FAULT: begin
        if (bus.start && !bus.alarme_rolha) w_next = S_IDLE;
      end
      default: begin
        w_next     = S_IDLE;
        w_next_idx = '0;
      end
    endcase

    // The alarm commits the pending transition's side effects but parks in PAUSED;
    // a bare timeout under alarm resumes into the interrupted state, not FAULT.
    if (w_active) begin
      w_next_idx   = w_base_idx;
      w_reject_inc = w_base_reject;
      if (bus.alarme_rolha) begin
        w_next       = S_PAUSED;
        w_next_saved = (w_base == S_FAULT) ? r_state : w_base;
      end else begin
        w_next = w_base;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state          <= S_IDLE;
      r_saved          <= S_IDLE;
      r_idx            <= '0;
      r_item           <= '0;
      r_batch          <= '0;
      r_reject         <= '0;
      r_batch_complete <= 1'b0;
      r_sensor_prev    <= 1'b0;
    end else begin
      r_state          <= w_next;
      r_saved          <= w_next_saved;
      r_idx            <= w_next_idx;
      r_sensor_prev    <= bus.sensor_final;
      r_batch_complete <= 1'b0;
      if (w_reject_inc && (r_reject != {CNT_W{1'b1}})) r_reject <= r_reject + 1'b1;
      if (w_count_inc) begin
        if (r_item == ITEM_MAX) begin
          r_item           <= '0;
          r_batch          <= r_batch + 1'b1;
          r_batch_complete <= 1'b1;
        end else begin
          r_item <= r_item + 1'b1;
        end
      end
    end
  end

  temporizador_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_W        (TO_W)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   ((w_next != r_state) || (w_next_idx != r_idx)),
    .enable  (w_active || (r_state == S_COUNT)),
    .expired (w_expired)
  );

  always_comb begin
    w_cmd_stage = '0;
    if (r_state == S_RUN) w_cmd_stage[r_idx] = 1'b1;
  end

  assign bus.cmd_mover_esteira = (r_state == S_MOVE) || (r_state == S_MOVE_FINAL);
  assign bus.cmd_stage         = w_cmd_stage;
  assign bus.batch_complete    = r_batch_complete;
  assign bus.item_count        = r_item;
  assign bus.batch_count       = r_batch;
  assign bus.reject_count      = r_reject;
  assign bus.paused            = (r_state == S_PAUSED);
  assign bus.fault             = (r_state == S_FAULT);
  assign bus.stage_idx         = r_idx;

endmodule

`default_nettype wire

// File: tb/tb_sequenciador_linha_param.sv
// ============================================================================
// Module : tb_sequenciador_linha_param
// Brief  : Directed bench for the bottling line sequencer (TIMEOUT_CYC = 100).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_sequenciador_linha_param;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   bc_pulses = 0;

  always #5 clk = ~clk;

  sequenciador_linha_param_if #(.N_STAGES(3), .BATCH_SIZE(12), .CNT_W(8)) bus ();

  sequenciador_linha_param #(
    .N_STAGES    (3),
    .MOVE_MASK   (3'b101),
    .BATCH_SIZE  (12),
    .CNT_W       (8),
    .TIMEOUT_CYC (100),
    .TO_W        (7)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always @(negedge clk) if (bus.batch_complete === 1'b1) bc_pulses++;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    bus.start = 1'b1; step(1); bus.start = 1'b0;
  endtask

  task automatic pulse_esteira();
    bus.esteira_concluida = 1'b1; step(1); bus.esteira_concluida = 1'b0;
  endtask

  task automatic pulse_stage(input int k, input logic ok);
    bus.stage_done = 3'b001 << k; bus.garrafa_aprovada = ok; step(1);
    bus.stage_done = 3'b000; bus.garrafa_aprovada = 1'b0;
  endtask

  task automatic sensor_rise();
    bus.sensor_final = 1'b1; step(1); bus.sensor_final = 1'b0;
  endtask

  task automatic full_cycle(input logic ok);
    do_start(); pulse_esteira(); pulse_stage(0, 1'b0); pulse_stage(1, 1'b0);
    pulse_esteira(); pulse_stage(2, ok);
    if (ok) begin pulse_esteira(); sensor_rise(); end
  endtask

  task automatic test_reset();
    step(2);
    n_cmp++; if ({bus.cmd_mover_esteira, bus.cmd_stage, bus.paused, bus.fault} !== 6'b0) begin
      n_err++; $display("FAIL reset_cmds: got %b expected 000000", {bus.cmd_mover_esteira, bus.cmd_stage, bus.paused, bus.fault}); end
    n_cmp++; if ({bus.item_count, bus.batch_count, bus.reject_count, bus.stage_idx} !== 22'd0) begin
      n_err++; $display("FAIL reset_counters: got %h expected 0", {bus.item_count, bus.batch_count, bus.reject_count, bus.stage_idx}); end
    reset = 1'b1;
    step(2);
  endtask

  task automatic test_single_cycle();
    do_start();
    n_cmp++; if ({bus.cmd_mover_esteira, bus.cmd_stage} !== 4'b1000) begin
      n_err++; $display("FAIL seq_move0: got %b expected 1000", {bus.cmd_mover_esteira, bus.cmd_stage}); end
    pulse_esteira();
    n_cmp++; if ({bus.cmd_mover_esteira, bus.cmd_stage} !== 4'b0001) begin
      n_err++; $display("FAIL seq_run0: got %b expected 0001", {bus.cmd_mover_esteira, bus.cmd_stage}); end
    pulse_stage(0, 1'b0);
    n_cmp++; if ({bus.cmd_mover_esteira, bus.cmd_stage} !== 4'b0010) begin
      n_err++; $display("FAIL seq_run1: got %b expected 0010", {bus.cmd_mover_esteira, bus.cmd_stage}); end
    pulse_stage(1, 1'b0);
    n_cmp++; if ({bus.cmd_mover_esteira, bus.cmd_stage, bus.stage_idx} !== 6'b100010) begin
      n_err++; $display("FAIL seq_move2: got %b expected 100010", {bus.cmd_mover_esteira, bus.cmd_stage, bus.stage_idx}); end
    pulse_esteira();
    n_cmp++; if ({bus.cmd_mover_esteira, bus.cmd_stage} !== 4'b0100) begin
      n_err++; $display("FAIL seq_run2: got %b expected 0100", {bus.cmd_mover_esteira, bus.cmd_stage}); end
    pulse_stage(2, 1'b1);
    n_cmp++; if ({bus.cmd_mover_esteira, bus.cmd_stage} !== 4'b1000) begin
      n_err++; $display("FAIL seq_move_final: got %b expected 1000", {bus.cmd_mover_esteira, bus.cmd_stage}); end
    pulse_esteira();
    n_cmp++; if ({bus.cmd_mover_esteira, bus.cmd_stage, bus.item_count} !== 8'h00) begin
      n_err++; $display("FAIL seq_count: got %b expected 00000000", {bus.cmd_mover_esteira, bus.cmd_stage, bus.item_count}); end
    sensor_rise();
    n_cmp++; if (bus.item_count !== 4'd1) begin
      n_err++; $display("FAIL seq_item1: got %0d expected 1", bus.item_count); end
    step(3);
    n_cmp++; if ({bus.cmd_mover_esteira, bus.cmd_stage, bus.item_count} !== 8'h01) begin
      n_err++; $display("FAIL seq_idle: got %b expected 00000001", {bus.cmd_mover_esteira, bus.cmd_stage, bus.item_count}); end
  endtask

  task automatic test_batch();
    for (int i = 0; i < 10; i++) full_cycle(1'b1);
    step(1);
    n_cmp++; if ({bus.item_count, bus.batch_count} !== {4'd11, 8'd0} || bc_pulses != 0) begin
      n_err++; $display("FAIL batch_pre: got item=%0d batch=%0d pulses=%0d expected 11 0 0", bus.item_count, bus.batch_count, bc_pulses); end
    full_cycle(1'b1);
    n_cmp++; if (bus.batch_complete !== 1'b1) begin
      n_err++; $display("FAIL batch_pulse: got %b expected 1", bus.batch_complete); end
    step(2);
    n_cmp++; if ({bus.item_count, bus.batch_count} !== {4'd0, 8'd1} || bc_pulses != 1) begin
      n_err++; $display("FAIL batch_done: got item=%0d batch=%0d pulses=%0d expected 0 1 1", bus.item_count, bus.batch_count, bc_pulses); end
  endtask

  task automatic test_reject();
    full_cycle(1'b1);
    full_cycle(1'b0);
    n_cmp++; if ({bus.reject_count, bus.item_count, bus.cmd_mover_esteira, bus.cmd_stage} !== {8'd1, 4'd1, 4'b0}) begin
      n_err++; $display("FAIL reject_one: got rej=%0d item=%0d cmd=%b expected 1 1 0000", bus.reject_count, bus.item_count, {bus.cmd_mover_esteira, bus.cmd_stage}); end
    for (int i = 0; i < 253; i++) full_cycle(1'b0);
    n_cmp++; if (bus.reject_count !== 8'd254) begin
      n_err++; $display("FAIL reject_254: got %0d expected 254", bus.reject_count); end
    for (int i = 0; i < 46; i++) full_cycle(1'b0);
    n_cmp++; if ({bus.reject_count, bus.batch_count, bus.item_count} !== {8'd255, 8'd1, 4'd1}) begin
      n_err++; $display("FAIL reject_sat: got rej=%0d batch=%0d item=%0d expected 255 1 1", bus.reject_count, bus.batch_count, bus.item_count); end
  endtask

  task automatic test_alarm_run1();
    do_start(); pulse_esteira(); pulse_stage(0, 1'b0);
    bus.alarme_rolha = 1'b1; step(1);
    n_cmp++; if ({bus.paused, bus.cmd_mover_esteira, bus.cmd_stage} !== 5'b10000) begin
      n_err++; $display("FAIL alarm_pause: got %b expected 10000", {bus.paused, bus.cmd_mover_esteira, bus.cmd_stage}); end
    do_start(); step(1);
    n_cmp++; if ({bus.paused, bus.cmd_stage} !== 4'b1000) begin
      n_err++; $display("FAIL alarm_hold: got %b expected 1000", {bus.paused, bus.cmd_stage}); end
    bus.alarme_rolha = 1'b0; step(2); do_start();
    n_cmp++; if ({bus.paused, bus.cmd_mover_esteira, bus.cmd_stage} !== 5'b00010) begin
      n_err++; $display("FAIL alarm_resume: got %b expected 00010", {bus.paused, bus.cmd_mover_esteira, bus.cmd_stage}); end
    pulse_stage(1, 1'b0); pulse_esteira(); pulse_stage(2, 1'b0);
  endtask

  task automatic test_alarm_with_done();
    do_start(); pulse_esteira();
    bus.alarme_rolha = 1'b1; bus.stage_done = 3'b001; step(1);
    bus.alarme_rolha = 1'b0; bus.stage_done = 3'b000;
    n_cmp++; if ({bus.paused, bus.cmd_stage, bus.stage_idx} !== 6'b100001) begin
      n_err++; $display("FAIL alarm_done_pause: got %b expected 100001", {bus.paused, bus.cmd_stage, bus.stage_idx}); end
    step(2); do_start();
    n_cmp++; if ({bus.paused, bus.cmd_mover_esteira, bus.cmd_stage} !== 5'b00010) begin
      n_err++; $display("FAIL alarm_done_resume: got %b expected 00010", {bus.paused, bus.cmd_mover_esteira, bus.cmd_stage}); end
    pulse_stage(1, 1'b0); pulse_esteira(); pulse_stage(2, 1'b0);
  endtask

  task automatic test_watchdog();
    do_start();
    step(99);
    n_cmp++; if ({bus.fault, bus.cmd_mover_esteira} !== 2'b01) begin
      n_err++; $display("FAIL wd_before: got %b expected 01", {bus.fault, bus.cmd_mover_esteira}); end
    step(1);
    n_cmp++; if ({bus.fault, bus.cmd_mover_esteira, bus.cmd_stage} !== 5'b10000) begin
      n_err++; $display("FAIL wd_fault: got %b expected 10000", {bus.fault, bus.cmd_mover_esteira, bus.cmd_stage}); end
    do_start();
    n_cmp++; if ({bus.fault, bus.cmd_mover_esteira, bus.cmd_stage, bus.reject_count} !== {5'b0, 8'd255}) begin
      n_err++; $display("FAIL wd_recover: got %b rej=%0d expected 00000 255", {bus.fault, bus.cmd_mover_esteira, bus.cmd_stage}, bus.reject_count); end
    do_start();
    step(99);
    bus.esteira_concluida = 1'b1; step(1); bus.esteira_concluida = 1'b0;
    n_cmp++; if ({bus.fault, bus.cmd_stage} !== 4'b0001) begin
      n_err++; $display("FAIL wd_done_wins: got %b expected 0001", {bus.fault, bus.cmd_stage}); end
    pulse_stage(0, 1'b0); pulse_stage(1, 1'b0); pulse_esteira(); pulse_stage(2, 1'b0);
  endtask

  task automatic test_reset_mid();
    do_start(); pulse_esteira();
    reset = 1'b0; #2;
    n_cmp++; if ({bus.cmd_stage, bus.batch_count, bus.reject_count, bus.item_count} !== 23'd0) begin
      n_err++; $display("FAIL reset_mid: got cmd=%b batch=%0d rej=%0d item=%0d expected 0", bus.cmd_stage, bus.batch_count, bus.reject_count, bus.item_count); end
    step(1); reset = 1'b1; step(1);
  endtask

  initial begin
    bus.start = 1'b0; bus.alarme_rolha = 1'b0; bus.sensor_final = 1'b0;
    bus.esteira_concluida = 1'b0; bus.stage_done = 3'b000; bus.garrafa_aprovada = 1'b0;
    test_reset();
    test_single_cycle();
    test_batch();
    test_reject();
    test_alarm_run1();
    test_alarm_with_done();
    test_watchdog();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete, expected finish before 2000000");
    $fatal(1, "global timeout");
  end

endmodule

`default_nettype wire
